// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // PIPE_PRI: pipeline owns the port; MDU_FORCE: one-cycle forced buffer grant.
  typedef enum logic {
    PIPE_PRI  = 1'b0,
    MDU_FORCE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_result_buffer.sv
// One-entry holding register for MDU results waiting for the write port.
module wb_result_buffer
  import wb_port_arbiter_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            drain,
  input  logic            supersede,
  output logic            ready,
  output logic            buf_valid,
  output logic [4:0]      buf_rd,
  output logic [XLEN-1:0] buf_data
);
  // The slot is free when empty or when its contents leave at this edge.
  assign ready = !buf_valid || drain || supersede;

  // Load on acceptance (rd=0 results are dropped), otherwise empty on drain/supersede.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_valid <= 1'b0;
      buf_rd    <= REG_ZERO;
      buf_data  <= '0;
    end else if (in_valid && ready) begin
      buf_valid <= (in_rd != REG_ZERO);
      buf_rd    <= in_rd;
      buf_data  <= in_data;
    end else if (drain || supersede) begin
      buf_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between MEM/WB and the MDU.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pipe_reg_write,
  input  logic             i_pipe_mem_to_reg,
  input  logic [4:0]       i_pipe_rd,
  input  logic [XLEN-1:0]  i_pipe_read_data,
  input  logic [XLEN-1:0]  i_pipe_alu_result,
  input  logic             i_mdu_valid,
  input  logic [4:0]       i_mdu_rd,
  input  logic [XLEN-1:0]  i_mdu_data,
  output logic             o_mdu_ready,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_rd,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic             o_stall_pipe,
  output logic [CNT_W-1:0] o_conflict_count
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e      state;
  logic [3:0]      wait_cnt;
  logic [CNT_W-1:0] conflict_cnt;

  logic            pipe_req;
  logic [XLEN-1:0] pipe_wdata;
  logic            grant_pipe, grant_buf, supersede, stall;
  logic            buf_ready, buf_valid;
  logic [4:0]      buf_rd;
  logic [XLEN-1:0] buf_data;

  assign pipe_req   = i_pipe_reg_write && (i_pipe_rd != REG_ZERO);
  assign pipe_wdata = i_pipe_mem_to_reg ? i_pipe_read_data : i_pipe_alu_result;

  wb_result_buffer u_buf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .in_valid  (i_mdu_valid),
    .in_rd     (i_mdu_rd),
    .in_data   (i_mdu_data),
    .drain     (grant_buf),
    .supersede (supersede),
    .ready     (buf_ready),
    .buf_valid (buf_valid),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data)
  );

  // Same-cycle grant: pipeline first unless the buffer is being forced through.
  always_comb begin
    grant_pipe = 1'b0;
    grant_buf  = 1'b0;
    supersede  = 1'b0;
    stall      = 1'b0;
    if (!i_reset) begin
      if (state == MDU_FORCE) begin
        grant_buf = buf_valid;
        stall     = pipe_req && buf_valid;
      end else begin
        grant_pipe = pipe_req;
        grant_buf  = !pipe_req && buf_valid;
        supersede  = pipe_req && buf_valid && (buf_rd == i_pipe_rd);
      end
    end
  end

  // Drive the write port from whichever source won; everything is quiet in reset.
  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_rd    = REG_ZERO;
    o_rf_wdata = '0;
    if (grant_buf) begin
      o_rf_we    = 1'b1;
      o_rf_rd    = buf_rd;
      o_rf_wdata = buf_data;
    end else if (grant_pipe) begin
      o_rf_we    = 1'b1;
      o_rf_rd    = i_pipe_rd;
      o_rf_wdata = pipe_wdata;
    end
  end

  assign o_mdu_ready      = !i_reset && buf_ready;
  assign o_stall_pipe     = stall;
  assign o_conflict_count = i_reset ? '0 : conflict_cnt;

  // Starvation FSM: count denied edges of a held result, then force one grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= PIPE_PRI;
      wait_cnt <= '0;
    end else begin
      case (state)
        PIPE_PRI: begin
          if (buf_valid && !grant_buf && !supersede) begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt + 4'd1 == LIMIT) state <= MDU_FORCE;
          end else begin
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= PIPE_PRI;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of pipeline stall cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) conflict_cnt <= '0;
    else if (stall && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// compared against a rule-level reference model.
module tb_wb_port_arbiter;
  localparam int LIMIT = 4;
  localparam int CW    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we, p_m2r;
  logic [4:0]  p_rd;
  logic [31:0] p_rdata, p_alu;
  logic        m_v;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        mdu_ready, rf_we, stall;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [CW-1:0] ccount;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  int          md_wait;
  bit          md_force;
  int          md_cnt;

  // expectations of the most recent step (for table/hand checks)
  bit          e_we, e_stall, e_ready;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_pipe_reg_write(p_we), .i_pipe_mem_to_reg(p_m2r), .i_pipe_rd(p_rd),
    .i_pipe_read_data(p_rdata), .i_pipe_alu_result(p_alu),
    .i_mdu_valid(m_v), .i_mdu_rd(m_rd), .i_mdu_data(m_data),
    .o_mdu_ready(mdu_ready), .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wdata(rf_wdata),
    .o_stall_pipe(stall), .o_conflict_count(ccount)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    p_we = 0; p_m2r = 0; p_rd = 0; p_rdata = 0; p_alu = 0;
    m_v = 0; m_rd = 0; m_data = 0;
  endtask

  // One cycle: inputs already driven just after an edge. Predict from the rules,
  // compare at mid-cycle, then advance the model across the clock edge.
  task automatic step(input string nm);
    bit preq, gp, gb, sup, st, rdy;
    logic [31:0] pw;
    preq = p_we && (p_rd != 0);
    pw   = p_m2r ? p_rdata : p_alu;
    gp = 0; gb = 0; sup = 0; st = 0; rdy = 0;
    if (!rst) begin
      if (md_force) begin
        gb = md_valid; st = preq;
      end else begin
        gp = preq; gb = !preq && md_valid;
        sup = preq && md_valid && (md_rd == p_rd);
      end
      rdy = !md_valid || gb || sup;
    end
    e_we = gb || gp; e_stall = st; e_ready = rdy;
    e_rd = gb ? md_rd : (gp ? p_rd : 5'd0);
    e_wd = gb ? md_data : (gp ? pw : 32'd0);
    #4;
    chk({nm, ".we"},    rf_we,     e_we);
    chk({nm, ".rd"},    rf_rd,     e_rd);
    chk({nm, ".wdata"}, rf_wdata,  e_wd);
    chk({nm, ".stall"}, stall,     e_stall);
    chk({nm, ".ready"}, mdu_ready, e_ready);
    chk({nm, ".count"}, ccount,    rst ? 0 : md_cnt);
    // next model state
    if (rst) begin
      md_valid = 0; md_wait = 0; md_force = 0; md_cnt = 0;
    end else begin
      if (md_force) begin
        md_force = 0; md_wait = 0;
      end else if (md_valid && !gb && !sup) begin
        md_wait++;
        if (md_wait == LIMIT) md_force = 1;
      end else begin
        md_wait = 0;
      end
      if (st && md_cnt < (1 << CW) - 1) md_cnt++;
      if (m_v && rdy) begin
        md_valid = (m_rd != 0); md_rd = m_rd; md_data = m_data;
      end else if (gb || sup) begin
        md_valid = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit p_we; bit p_m2r; logic [4:0] p_rd; logic [31:0] p_rdata; logic [31:0] p_alu;
    bit m_v; logic [4:0] m_rd; logic [31:0] m_data;
    bit x_we; logic [4:0] x_rd; logic [31:0] x_wd; bit x_stall; bit x_ready;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // p_we m2r rd rdata alu | mv mrd mdata | we rd wd stall ready
    tbl[0] = '{1,1,5,32'hDEADBEEF,0,      0,0,0,      1,5,32'hDEADBEEF,0,1};
    tbl[1] = '{0,0,0,0,0,                 1,7,32'h12, 0,0,0,0,1};
    tbl[2] = '{0,0,0,0,0,                 0,0,0,      1,7,32'h12,0,1};
    tbl[3] = '{0,0,0,0,0,                 0,0,0,      0,0,0,0,1};
    tbl[4] = '{1,0,0,0,32'h55,            1,0,32'h99, 0,0,0,0,1};
    tbl[5] = '{0,0,0,0,0,                 0,0,0,      0,0,0,0,1};
    tbl[6] = '{0,0,0,0,0,                 1,8,32'h1,  0,0,0,0,1};
    tbl[7] = '{1,0,8,32'h7,32'h2,         0,0,0,      1,8,32'h2,0,1};
    tbl[8] = '{0,0,0,0,0,                 0,0,0,      0,0,0,0,1};
    tbl[9] = '{1,0,31,0,32'hA5,           0,0,0,      1,31,32'hA5,0,1};

    idle();
    rst = 1;
    md_valid = 0; md_rd = 0; md_data = 0; md_wait = 0; md_force = 0; md_cnt = 0;
    @(posedge clk); #1;
    step("reset");
    chk("reset.we_zero", rf_we, 0);
    chk("reset.ready_zero", mdu_ready, 0);
    rst = 0;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      p_we = tbl[i].p_we; p_m2r = tbl[i].p_m2r; p_rd = tbl[i].p_rd;
      p_rdata = tbl[i].p_rdata; p_alu = tbl[i].p_alu;
      m_v = tbl[i].m_v; m_rd = tbl[i].m_rd; m_data = tbl[i].m_data;
      #4;
      chk($sformatf("vec%0d.we", i),    rf_we,     tbl[i].x_we);
      chk($sformatf("vec%0d.rd", i),    rf_rd,     tbl[i].x_rd);
      chk($sformatf("vec%0d.wd", i),    rf_wdata,  tbl[i].x_wd);
      chk($sformatf("vec%0d.stall", i), stall,     tbl[i].x_stall);
      chk($sformatf("vec%0d.ready", i), mdu_ready, tbl[i].x_ready);
      #(-0); // stay mid-cycle; step re-samples after its own delay
      @(posedge clk); #1;
      // keep the model in step with the table traffic
      if (i == 1) begin md_valid = 1; md_rd = 7; md_data = 32'h12; end
      if (i == 2) md_valid = 0;
      if (i == 6) begin md_valid = 1; md_rd = 8; md_data = 32'h1; end
      if (i == 7) md_valid = 0;
    end
    idle();
    step("waw.after");
    chk("waw.count_unchanged", ccount, 0);

    // starvation: buffered rd=3 denied LIMIT times, then forced through
    m_v = 1; m_rd = 3; m_data = 32'h33;
    step("starve.accept");
    m_v = 0;
    for (int k = 0; k < LIMIT; k++) begin
      p_we = 1; p_rd = 5'(9 + k); p_alu = 32'h900 + k;
      step($sformatf("starve.pipe%0d", k));
      chk($sformatf("starve.pipe%0d.rd", k), e_rd, 5'(9 + k));
    end
    p_rd = 13; p_alu = 32'hD13;
    step("starve.force");
    chk("starve.force_rd", e_rd, 3);
    chk("starve.force_stall", e_stall, 1);
    chk("starve.count", ccount, 1);
    step("starve.retry");
    chk("starve.retry_rd", rf_rd, 13);
    idle();
    step("starve.idle");

    // reset while in MDU_FORCE with a buffered entry
    m_v = 1; m_rd = 4; m_data = 32'h44;
    step("rst.accept");
    m_v = 0;
    for (int k = 0; k < LIMIT; k++) begin
      p_we = 1; p_rd = 5'(20 + k); p_alu = 32'h2000 + k;
      step($sformatf("rst.pipe%0d", k));
    end
    chk("rst.in_force", md_force, 1);
    rst = 1;
    step("rst.force_cycle");
    chk("rst.force_we", rf_we, 0);
    step("rst.hold");
    rst = 0; idle();
    step("rst.released");
    chk("rst.no_old_write", rf_we, 0);
    chk("rst.count_zero", ccount, 0);
    p_we = 1; p_rd = 6; p_alu = 32'h66;
    step("rst.pipe_pri");
    chk("rst.no_stall", stall, 0);
    idle();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      p_we    = ($urandom_range(0, 9) < 7);
      p_m2r   = $urandom_range(0, 1);
      p_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      p_rdata = $urandom;
      p_alu   = $urandom;
      m_v     = $urandom_range(0, 1);
      m_rd    = 5'($urandom_range(0, 4));
      m_data  = $urandom;
      step($sformatf("rand%0d", n));
    end
    rst = 0; idle();
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
